if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

- Instruction-fetch stage of the pipelined MIPS core.
- Owns the architectural PC register and produces the fetch address for instruction memory.
- Generates the sequential next address and accepts branch/jump redirects from ID, parking a redirect that arrives during a stall.
- Drives the IF/ID pipeline register (instr, pc, pc+4, valid) consumed by the decode stage.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; freezes PC and IF/ID.
- id_clr  in  1  inserts a bubble into IF/ID; PC still advances per normal rules.
- redirect_valid  in  1  ID-stage branch taken / j / jal / jr.
- redirect_pc  in  32  redirect target.
- im_instr  in  32  instruction word read from IM at address pc (combinational IM).
- pc  out  32  current fetch address to IM.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID PC.
- id_pc4  out  32  IF/ID PC+4.
- id_valid  out  1  IF/ID holds a real instruction.
- addr_err  out  1  misaligned redirect flag (see Configuration).

## Operation
- Internal state: pc, pend_valid, pend_pc, IF/ID registers, addr_err register.
- Next-PC priority, evaluated on each non-reset clock edge:
  1. stall=1: pc holds. If redirect_valid=1, then pend_valid<=1 and pend_pc<=redirect_pc; a newer redirect overwrites an older pending one.
  2. redirect_valid=1: pc<=redirect_pc, pend_valid<=0. A live redirect beats a pending one.
  3. pend_valid=1: pc<=pend_pc, pend_valid<=0.
  4. Otherwise: pc<=pc+32'd4. Arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- IF/ID update priority:
  - id_clr=1 beats stall: id_instr<=0 (nop), id_valid<=0, id_pc<=pc, id_pc4<=pc+4.
  - Else stall=1: all IF/ID registers hold.
  - Else: id_instr<=im_instr, id_pc<=pc, id_pc4<=pc+4, id_valid<=1.
- Delay slot: a redirect never flushes IF/ID. The instruction fetched in the same cycle as the redirect enters ID as the delay slot.

## Timing
- Reset (asynchronous, immediate, independent of clk) sets:
  - pc=RESET_PC
  - id_instr=0, id_pc=RESET_PC, id_pc4=RESET_PC+4, id_valid=0
  - pend_valid=0, addr_err=0
- Reset asserted mid-stall or with a pending redirect discards the pending redirect.
- Fetch latency is 1 cycle: the word at pc appears on id_instr after the next non-stalled edge.
- Redirect latency: redirect_valid sampled at edge N gives pc=redirect_pc after N. The target instruction reaches id_instr after edge N+1.
- A redirect during stall is applied on the first edge where stall=0, even if redirect_valid is low by then. There is no lost and no duplicated redirect.
- id_clr and stall together: IF/ID becomes a bubble and pc holds.
- No combinational path from any input to pc or any id_* output; all outputs are registered.

## Configuration
- ALIGN_CHECK_EN defined:
  - On any edge that loads pc from redirect_pc or pend_pc with bits [1:0]≠0, pc loads the target with bits [1:0] forced to 00.
  - addr_err is set to 1 for exactly one cycle after that edge, then cleared.
- ALIGN_CHECK_EN undefined:
  - Targets are loaded verbatim.
  - addr_err is constant 0.
  - pc+4 still preserves whatever low bits were loaded.

## Test plan
- Reset then 3 free-running edges, im_instr=32'h2408_0001 -> pc=3000,3004,3008,300C; id_valid=1 from the first edge; id_pc=3008, id_pc4=300C after the third edge.
- Redirect at pc=3010 with redirect_pc=3100 -> next pc=3100. id_instr after that edge is the word fetched at 3010 (delay slot, valid=1). The target word follows one edge later.
- stall=1 for 2 edges with redirect_valid=1 (redirect_pc=3200) on the first edge only -> pc and IF/ID frozen. On the first unstalled edge pc=3200, and pend_valid is 0 afterwards.
- id_clr=1 with stall=1 -> id_valid=0, id_instr=0, pc unchanged. With id_clr=1 and stall=0, pc advances by 4.
- pc forced via redirect to FFFF_FFFC, one free edge -> pc=0000_0000.
- With ALIGN_CHECK_EN, redirect_pc=3102 -> pc=3100 and addr_err=1 for one cycle. Without the macro: pc=3102, addr_err=0, next pc=3106.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, parks redirects that arrive during a stall, drives IF/ID.
// Optional macro ALIGN_CHECK_EN forces redirect targets to word alignment and pulses addr_err.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_clr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] im_instr,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        addr_err
);

  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] target;
  logic [31:0] load_pc;
  logic        take_target;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  // A live redirect wins over a parked one; either is only consumed on an unstalled edge.
  always_comb begin
    target      = pend_pc;
    take_target = 1'b0;
    if (redirect_valid) begin
      target = redirect_pc;
    end
    if (!stall && (redirect_valid || pend_valid)) begin
      take_target = 1'b1;
    end
  end

`ifdef ALIGN_CHECK_EN
  logic addr_err_q;
  logic misaligned;

  assign misaligned = take_target && (target[1:0] != 2'b00);
  assign load_pc    = {target[31:2], 2'b00};
  assign addr_err   = addr_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= misaligned;
    end
  end
`else
  assign load_pc  = target;
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'd0;
    end else if (stall) begin
      if (redirect_valid) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end
    end else if (take_target) begin
      pc         <= load_pc;
      pend_valid <= 1'b0;
    end else begin
      pc <= pc_plus4;
    end
  end

  // Bubble insertion beats stall; a redirect never flushes, so the same-cycle fetch is the delay slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_instr <= 32'd0;
      id_pc    <= RESET_PC;
      id_pc4   <= RESET_PC + 32'd4;
      id_valid <= 1'b0;
    end else if (id_clr) begin
      id_instr <= 32'd0;
      id_pc    <= pc;
      id_pc4   <= pc_plus4;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_instr <= im_instr;
      id_pc    <= pc;
      id_pc4   <= pc_plus4;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        id_clr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] im_instr;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_pend_pc;
  logic        m_valid, m_pend_v, m_err;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .id_clr(id_clr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .im_instr(im_instr),
    .pc(pc), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_valid(id_valid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_instr = 32'd0; m_id_pc = 32'h0000_3000;
    m_id_pc4 = 32'h0000_3004; m_valid = 1'b0; m_pend_v = 1'b0; m_pend_pc = 32'd0; m_err = 1'b0;
  endtask

  // Applies the fetch rules to the model using the inputs present at this edge.
  task automatic model_step();
    logic [31:0] cur, tgt;
    cur = m_pc;
    if (id_clr) begin
      m_instr = 32'd0; m_valid = 1'b0; m_id_pc = cur; m_id_pc4 = cur + 32'd4;
    end else if (!stall) begin
      m_instr = im_instr; m_valid = 1'b1; m_id_pc = cur; m_id_pc4 = cur + 32'd4;
    end
    m_err = 1'b0;
    if (stall) begin
      if (redirect_valid) begin
        m_pend_v = 1'b1; m_pend_pc = redirect_pc;
      end
    end else if (redirect_valid || m_pend_v) begin
      tgt = redirect_valid ? redirect_pc : m_pend_pc;
      m_pend_v = 1'b0;
`ifdef ALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) begin
        m_err = 1'b1;
        tgt[1:0] = 2'b00;
      end
`endif
      m_pc = tgt;
    end else begin
      m_pc = cur + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    stall = 1'b0; id_clr = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_5000; im_instr = 32'h1234_5678;
    tick();
    checks++; if (pc !== 32'h0000_3000) begin failures++; $display("[TB] FAIL rst_stall_pc got=%h want=%h", pc, 32'h0000_3000); end
    reset = 1'b1;
    #2;
    model_reset();
    checks++; if (pc !== 32'h0000_3000) begin failures++; $display("[TB] FAIL rst_pc got=%h want=%h", pc, 32'h0000_3000); end
    checks++; if (id_instr !== 32'd0) begin failures++; $display("[TB] FAIL rst_id_instr got=%h want=0", id_instr); end
    checks++; if (id_pc !== 32'h0000_3000) begin failures++; $display("[TB] FAIL rst_id_pc got=%h want=%h", id_pc, 32'h0000_3000); end
    checks++; if (id_pc4 !== 32'h0000_3004) begin failures++; $display("[TB] FAIL rst_id_pc4 got=%h want=%h", id_pc4, 32'h0000_3004); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_id_valid got=%b want=0", id_valid); end
    checks++; if (addr_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_addr_err got=%b want=0", addr_err); end
    reset = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    checks++; if (pc !== 32'h0000_3004) begin failures++; $display("[TB] FAIL rst_drops_pending got=%h want=%h", pc, 32'h0000_3004); end
  endtask

  task automatic test_sequential();
    do_reset();
    im_instr = 32'h2408_0001;
    tick();
    checks++; if (pc !== 32'h0000_3004) begin failures++; $display("[TB] FAIL seq_pc1 got=%h want=%h", pc, 32'h0000_3004); end
    checks++; if (id_valid !== 1'b1) begin failures++; $display("[TB] FAIL seq_valid1 got=%b want=1", id_valid); end
    checks++; if (id_instr !== 32'h2408_0001) begin failures++; $display("[TB] FAIL seq_instr1 got=%h want=%h", id_instr, 32'h2408_0001); end
    checks++; if (id_pc !== 32'h0000_3000) begin failures++; $display("[TB] FAIL seq_id_pc1 got=%h want=%h", id_pc, 32'h0000_3000); end
    tick();
    checks++; if (pc !== 32'h0000_3008) begin failures++; $display("[TB] FAIL seq_pc2 got=%h want=%h", pc, 32'h0000_3008); end
    tick();
    checks++; if (pc !== 32'h0000_300C) begin failures++; $display("[TB] FAIL seq_pc3 got=%h want=%h", pc, 32'h0000_300C); end
    checks++; if (id_pc !== 32'h0000_3008) begin failures++; $display("[TB] FAIL seq_id_pc3 got=%h want=%h", id_pc, 32'h0000_3008); end
    checks++; if (id_pc4 !== 32'h0000_300C) begin failures++; $display("[TB] FAIL seq_id_pc4_3 got=%h want=%h", id_pc4, 32'h0000_300C); end
  endtask

  task automatic test_redirect();
    tick();
    checks++; if (pc !== 32'h0000_3010) begin failures++; $display("[TB] FAIL redir_pre_pc got=%h want=%h", pc, 32'h0000_3010); end
    im_instr = 32'hAAAA_0001; redirect_valid = 1'b1; redirect_pc = 32'h0000_3100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc !== 32'h0000_3100) begin failures++; $display("[TB] FAIL redir_pc got=%h want=%h", pc, 32'h0000_3100); end
    checks++; if (id_instr !== 32'hAAAA_0001) begin failures++; $display("[TB] FAIL redir_slot_instr got=%h want=%h", id_instr, 32'hAAAA_0001); end
    checks++; if (id_pc !== 32'h0000_3010) begin failures++; $display("[TB] FAIL redir_slot_pc got=%h want=%h", id_pc, 32'h0000_3010); end
    checks++; if (id_valid !== 1'b1) begin failures++; $display("[TB] FAIL redir_slot_valid got=%b want=1", id_valid); end
    im_instr = 32'hBBBB_0002;
    tick();
    checks++; if (id_pc !== 32'h0000_3100) begin failures++; $display("[TB] FAIL redir_tgt_id_pc got=%h want=%h", id_pc, 32'h0000_3100); end
    checks++; if (id_instr !== 32'hBBBB_0002) begin failures++; $display("[TB] FAIL redir_tgt_instr got=%h want=%h", id_instr, 32'hBBBB_0002); end
    checks++; if (pc !== 32'h0000_3104) begin failures++; $display("[TB] FAIL redir_after_pc got=%h want=%h", pc, 32'h0000_3104); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_3200; im_instr = 32'hCCCC_0003;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc !== 32'h0000_3104) begin failures++; $display("[TB] FAIL stall1_pc got=%h want=%h", pc, 32'h0000_3104); end
    checks++; if (id_pc !== 32'h0000_3100) begin failures++; $display("[TB] FAIL stall1_id_pc got=%h want=%h", id_pc, 32'h0000_3100); end
    checks++; if (id_instr !== 32'hBBBB_0002) begin failures++; $display("[TB] FAIL stall1_instr got=%h want=%h", id_instr, 32'hBBBB_0002); end
    tick();
    checks++; if (pc !== 32'h0000_3104) begin failures++; $display("[TB] FAIL stall2_pc got=%h want=%h", pc, 32'h0000_3104); end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h0000_3200) begin failures++; $display("[TB] FAIL pend_apply_pc got=%h want=%h", pc, 32'h0000_3200); end
    checks++; if (id_pc !== 32'h0000_3104) begin failures++; $display("[TB] FAIL pend_apply_id_pc got=%h want=%h", id_pc, 32'h0000_3104); end
    tick();
    checks++; if (pc !== 32'h0000_3204) begin failures++; $display("[TB] FAIL pend_cleared_pc got=%h want=%h", pc, 32'h0000_3204); end
  endtask

  task automatic test_clr();
    stall = 1'b1; id_clr = 1'b1;
    tick();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL clr_stall_valid got=%b want=0", id_valid); end
    checks++; if (id_instr !== 32'd0) begin failures++; $display("[TB] FAIL clr_stall_instr got=%h want=0", id_instr); end
    checks++; if (pc !== 32'h0000_3204) begin failures++; $display("[TB] FAIL clr_stall_pc got=%h want=%h", pc, 32'h0000_3204); end
    stall = 1'b0;
    tick();
    id_clr = 1'b0;
    checks++; if (pc !== 32'h0000_3208) begin failures++; $display("[TB] FAIL clr_run_pc got=%h want=%h", pc, 32'h0000_3208); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL clr_run_valid got=%b want=0", id_valid); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_load got=%h want=%h", pc, 32'hFFFF_FFFC); end
    tick();
    checks++; if (pc !== 32'h0000_0000) begin failures++; $display("[TB] FAIL wrap_pc got=%h want=0", pc); end
    checks++; if (id_pc4 !== 32'h0000_0000) begin failures++; $display("[TB] FAIL wrap_id_pc4 got=%h want=0", id_pc4); end
  endtask

  task automatic test_align();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3102;
    tick();
    redirect_valid = 1'b0;
`ifdef ALIGN_CHECK_EN
    checks++; if (pc !== 32'h0000_3100) begin failures++; $display("[TB] FAIL align_pc got=%h want=%h", pc, 32'h0000_3100); end
    checks++; if (addr_err !== 1'b1) begin failures++; $display("[TB] FAIL align_err got=%b want=1", addr_err); end
    tick();
    checks++; if (addr_err !== 1'b0) begin failures++; $display("[TB] FAIL align_err_clear got=%b want=0", addr_err); end
    checks++; if (pc !== 32'h0000_3104) begin failures++; $display("[TB] FAIL align_next_pc got=%h want=%h", pc, 32'h0000_3104); end
`else
    checks++; if (pc !== 32'h0000_3102) begin failures++; $display("[TB] FAIL noalign_pc got=%h want=%h", pc, 32'h0000_3102); end
    checks++; if (addr_err !== 1'b0) begin failures++; $display("[TB] FAIL noalign_err got=%b want=0", addr_err); end
    tick();
    checks++; if (pc !== 32'h0000_3106) begin failures++; $display("[TB] FAIL noalign_next_pc got=%h want=%h", pc, 32'h0000_3106); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall          = ($urandom_range(0, 3) == 0);
      id_clr         = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 4) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      im_instr       = $urandom;
      tick();
      checks++; if (pc !== m_pc) begin failures++; $display("[TB] FAIL rnd_pc cyc=%0d got=%h want=%h", i, pc, m_pc); end
      checks++; if (id_instr !== m_instr) begin failures++; $display("[TB] FAIL rnd_instr cyc=%0d got=%h want=%h", i, id_instr, m_instr); end
      checks++; if (id_pc !== m_id_pc) begin failures++; $display("[TB] FAIL rnd_id_pc cyc=%0d got=%h want=%h", i, id_pc, m_id_pc); end
      checks++; if (id_pc4 !== m_id_pc4) begin failures++; $display("[TB] FAIL rnd_id_pc4 cyc=%0d got=%h want=%h", i, id_pc4, m_id_pc4); end
      checks++; if (id_valid !== m_valid) begin failures++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b want=%b", i, id_valid, m_valid); end
      checks++; if (addr_err !== m_err) begin failures++; $display("[TB] FAIL rnd_addr_err cyc=%0d got=%b want=%b", i, addr_err, m_err); end
    end
    stall = 1'b0; id_clr = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; id_clr = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; im_instr = 32'd0;
    model_reset();
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_redirect();
    test_clr();
    test_wrap();
    test_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
